output_collector: RTL and testbench

OUTPUT_COLLECTOR -- requirements
Module: output_collector

---
 rtl/sys_defs.sv | 23 ++
 rtl/output_buffer.sv | 44 ++++
 rtl/output_collector.sv | 126 ++++++++++++
 tb/tb_output_collector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared constants, collector state encoding and sizing helper for the convolution
// output path.
package sys_defs;

    localparam int OUT_BIN_LEN   = 16;
    localparam int INPUT_HEIGHT  = 8;
    localparam int INPUT_WIDTH   = 8;
    localparam int KERNEL_HEIGHT = 3;
    localparam int KERNEL_WIDTH  = 3;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL,
        DONE
    } collect_state_e;

    // Address width for a memory of 'depth' entries; never narrower than one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/output_buffer.sv
// Feature-map sample store: one write port and one registered read port.
// Reads of the address being written return the previous contents.
module output_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OUT_BIN_LEN,
    parameter int AW    = addr_bits(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM; samples survive a reset.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking reads see the pre-write value, giving old-data on collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr_i} < DEPTH_C) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/output_collector.sv
// Gathers one frame of processing-unit results into the output buffer and flags
// short frames and overflow.
module output_collector
    import sys_defs::*;
#(
    parameter int OUT_H = INPUT_HEIGHT - KERNEL_HEIGHT + 1,
    parameter int OUT_W = INPUT_WIDTH - KERNEL_WIDTH + 1,
    parameter int RELU  = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [OUT_BIN_LEN-1:0]               output_val,
    input  logic                                 output_valid,
    input  logic                                 pu_done,
    input  logic [addr_bits(OUT_H*OUT_W)-1:0]    rd_addr,
    output logic [OUT_BIN_LEN-1:0]               rd_data,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 error
);

    localparam int DEPTH = OUT_H * OUT_W;
    localparam int AW    = addr_bits(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    collect_state_e         state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   error_q, error_d;
    logic                   wr_en;
    logic [OUT_BIN_LEN-1:0] wr_data;

    always_comb begin
        wr_data = output_val;
        if ((RELU != 0) && output_val[OUT_BIN_LEN-1]) begin
            wr_data = '0;
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        error_d  = error_q;
        wr_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = COLLECT;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    error_d  = 1'b0;
                end
            end
            COLLECT: begin
                if (output_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                // The end-of-frame test uses the count after any same-cycle write.
                if (pu_done) begin
                    if (count_d == DEPTH_C) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end else if (count_d == DEPTH_C) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (output_valid) begin
                    error_d = 1'b1;
                end
                if (pu_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    assign busy       = (state_q == COLLECT) || (state_q == FULL);
    assign frame_done = (state_q == DONE);
    assign error      = error_q;

    output_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_BIN_LEN),
        .AW    (AW)
    ) u_output_buffer (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_output_collector.sv
// Scoreboard bench: two 2x2 collectors (ReLU off / on) share one stimulus stream;
// expected read data and frame_done pulses are queued and checked by a monitor.
module tb_output_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] output_val = '0;
    logic        output_valid = 1'b0;
    logic        pu_done = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [15:0] rd0, rd1;
    logic        busy0, busy1, fd0, fd1, err0, err1;

    logic        rd_req = 1'b0;
    logic        rd_pending = 1'b0;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    bit          fd_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    output_collector #(.OUT_H(2), .OUT_W(2), .RELU(0)) u_relu0 (
        .clock(clock), .reset(reset), .start(start), .output_val(output_val),
        .output_valid(output_valid), .pu_done(pu_done), .rd_addr(rd_addr),
        .rd_data(rd0), .busy(busy0), .frame_done(fd0), .error(err0)
    );

    output_collector #(.OUT_H(2), .OUT_W(2), .RELU(1)) u_relu1 (
        .clock(clock), .reset(reset), .start(start), .output_val(output_val),
        .output_valid(output_valid), .pu_done(pu_done), .rd_addr(rd_addr),
        .rd_data(rd1), .busy(busy1), .frame_done(fd1), .error(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        output_valid = 1'b1;
        output_val   = v;
        tick();
        output_valid = 1'b0;
    endtask

    task automatic pulse_done();
        pu_done = 1'b1;
        tick();
        pu_done = 1'b0;
    endtask

    task automatic read(input logic [1:0] a, input logic [15:0] e0, input logic [15:0] e1);
        rd_addr = a;
        rd_req  = 1'b1;
        q0.push_back(e0);
        q1.push_back(e1);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic check_err(input string name, input logic e);
        check({name, "_relu0"}, err0, e);
        check({name, "_relu1"}, err1, e);
    endtask

    task automatic check_busy(input string name, input logic b);
        check({name, "_relu0"}, busy0, b);
        check({name, "_relu1"}, busy1, b);
    endtask

    always @(posedge clock) rd_pending <= rd_req;

    // Monitor: read data is due one cycle after the request; frame_done must be expected.
    always @(negedge clock) begin
        if (rd_pending) begin
            check("rd_queue_nonempty", q0.size() > 0 && q1.size() > 0, 1);
            if (q0.size() > 0) check("rd_data_relu0", rd0, q0.pop_front());
            if (q1.size() > 0) check("rd_data_relu1", rd1, q1.pop_front());
        end
        if (fd0 || fd1) begin
            if (fd_q.size() == 0) begin
                check("frame_done_unexpected", fd_q.size(), 1);
            end else begin
                void'(fd_q.pop_front());
                check("frame_done_relu0", fd0, 1);
                check("frame_done_relu1", fd1, 1);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_busy("reset_busy", 1'b0);
        check_err("reset_error", 1'b0);
        check("reset_fd", {fd0, fd1}, 2'b00);
        check("reset_rd", {rd0, rd1}, 32'h0);
        reset = 1'b0;
        tick();

        // Full frame 5, -3, 7, 0
        start_frame();
        check_busy("collect_busy", 1'b1);
        send(16'd5);
        send(16'hFFFD);
        send(16'd7);
        send(16'd0);
        check_busy("full_busy", 1'b1);
        fd_q.push_back(1'b1);
        pulse_done();
        tick();
        check_err("frame1_error", 1'b0);
        check_busy("frame1_idle", 1'b0);
        check("frame1_fd_seen", fd_q.size(), 0);
        read(2'd0, 16'd5, 16'd5);
        read(2'd1, 16'hFFFD, 16'd0);
        read(2'd2, 16'd7, 16'd7);
        read(2'd3, 16'd0, 16'd0);
        tick();

        // Short frame; first write collides with a read of the same address
        start_frame();
        rd_addr = 2'd0;
        rd_req  = 1'b1;
        q0.push_back(16'd5);
        q1.push_back(16'd5);
        send(16'd11);
        rd_req = 1'b0;
        send(16'd12);
        send(16'd13);
        pulse_done();
        check_err("short_error", 1'b1);
        check_busy("short_idle", 1'b0);

        // Restart clears error, then overflow: fifth sample dropped
        start_frame();
        check_err("restart_clears_error", 1'b0);
        check_busy("restart_busy", 1'b1);
        send(16'd21);
        send(16'd22);
        send(16'hFF00);
        send(16'd24);
        check_err("full_no_error", 1'b0);
        send(16'd25);
        check_err("overflow_error", 1'b1);
        fd_q.push_back(1'b1);
        pulse_done();
        tick();
        check_err("overflow_error_sticky", 1'b1);
        check("overflow_fd_seen", fd_q.size(), 0);
        read(2'd0, 16'd21, 16'd21);
        read(2'd2, 16'hFF00, 16'd0);
        read(2'd3, 16'd24, 16'd24);
        tick();

        // Stray start mid-frame, then fourth valid coincident with pu_done
        start_frame();
        send(16'd31);
        send(16'd32);
        start_frame();
        send(16'd33);
        fd_q.push_back(1'b1);
        output_valid = 1'b1;
        output_val   = 16'd34;
        pu_done      = 1'b1;
        tick();
        output_valid = 1'b0;
        pu_done      = 1'b0;
        tick();
        check_err("coincident_error", 1'b0);
        check("coincident_fd_seen", fd_q.size(), 0);
        read(2'd0, 16'd31, 16'd31);
        read(2'd3, 16'd34, 16'd34);
        tick();

        // Reset mid-frame: control cleared, memory kept
        start_frame();
        send(16'd41);
        send(16'd42);
        reset = 1'b1;
        tick();
        check_busy("midreset_busy", 1'b0);
        check_err("midreset_error", 1'b0);
        check("midreset_rd", {rd0, rd1}, 32'h0);
        reset = 1'b0;
        read(2'd2, 16'd33, 16'd33);
        read(2'd0, 16'd41, 16'd41);
        tick();

        // Following frame restarts from address 0
        start_frame();
        send(16'd51);
        send(16'hFFFE);
        send(16'd53);
        send(16'd54);
        fd_q.push_back(1'b1);
        pulse_done();
        tick();
        check_err("postreset_error", 1'b0);
        read(2'd0, 16'd51, 16'd51);
        read(2'd1, 16'hFFFE, 16'd0);
        read(2'd2, 16'd53, 16'd53);
        read(2'd3, 16'd54, 16'd54);
        tick();

        // output_valid while idle is ignored
        send(16'd99);
        check_err("idle_valid_error", 1'b0);
        check_busy("idle_valid_busy", 1'b0);
        read(2'd0, 16'd51, 16'd51);

        repeat (3) tick();
        check("rd_queue_drained", q0.size() + q1.size(), 0);
        check("fd_queue_drained", fd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
